canvas_scanner: RTL and testbench
=================================

Name: canvas_scanner

Overview:
- Read-side companion to the stroke writer that fills the 32x32 1-bit canvas RAM (addr = {y[4:0], x[4:0]}, data 1 = ink).
- On a start pulse, after editing ends, it raster-scans all 1024 pixels through the RAM's second (read) port.
- It produces the ink bounding box, the total ink count, and an 8x8 downsampled feature bitmap, which feed the character-recognition stage.

Parameters:
- THRESH, 4: minimum ink pixels in a 4x4 block for its feature bit to be 1; legal range 1..16.
- RD_LAT, 1: RAM read latency in cycles. Only 1 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle scan request
- rd_en  out  1  RAM read enable
- rd_addr  out  10  RAM read address {y,x}
- rd_data  in  1  pixel data; valid the cycle after rd_en
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse when results are valid
- bbox_valid  out  1  at least one ink pixel found
- min_x, min_y, max_x, max_y  out  5 each  bounding box, inclusive
- pixel_count  out  11  number of ink pixels, 0..1024
- feature  out  64  bit [by*8+bx] set if the ink count in block (bx,by) is >= THRESH; bx = x[4:2], by = y[4:2]

Behaviour:
- Reset: state IDLE. busy=0, done=0, rd_en=0, rd_addr=0, bbox_valid=0, all bbox fields=0, pixel_count=0, feature=0, all block counters=0.
- States:
  - IDLE -> SCAN on start.
  - SCAN issues addr 0..1023, one per cycle, with rd_en=1. After issuing 1023 -> DRAIN.
  - DRAIN: rd_en=0; the last pixel is processed. Next state DONE.
  - DONE: done=1 for one cycle. Next state IDLE.
- busy=1 in SCAN, DRAIN and DONE.
- Timing: start sampled at edge T. First rd_en cycle is T+1. done is high during cycle T+1026. Total busy window is 1026 cycles.
- start is ignored while busy. start in the same cycle as rst: rst wins.
- On the start edge:
  - clear pixel_count, bbox_valid, feature, and all counters.
  - bbox registers init to min=31, max=0.
- Pixel pipeline: the address is registered alongside rd_en (px_valid, px_x, px_y) so each rd_data is paired with its coordinates one cycle later.
- For each valid pixel with rd_data=1:
  - pixel_count += 1.
  - Update min/max with unsigned compares.
  - Set bbox_valid.
  - Increment block counter [px_x[4:2]]; counters are 5 bits, max 16, no saturation needed.
- At the last pixel of a block row (px_x==31 and px_y[1:0]==3):
  - Write feature[px_y[4:2]*8 + bx] = (cnt[bx] >= THRESH) for all 8 bx in that cycle.
  - Clear all 8 counters in the same cycle.
- Empty canvas:
  - bbox_valid=0 at done.
  - min/max are forced to 0 at DONE so no stale 31/0 values are presented.
- Results hold from done until the next accepted start or reset. Results are undefined while busy.
- rst mid-scan: return to IDLE next cycle, apply all reset values, no done pulse.
- The RAM may be written concurrently. The result then reflects the mixed snapshot; avoiding this is the controller's responsibility.

Decomposition:
- Shared package canvas_pkg:
  - CANVAS_DIM=32, CANVAS_ADDR_W=10, CELL_SHIFT=5.
  - BLK_DIM=4, FEAT_DIM=8, FEAT_W=64.
  - State enum IDLE/SCAN/DRAIN/DONE.
  - Used by both the writer and canvas_scanner.
- One sub-module, block_row_accum: holds the 8 x 5-bit counters.
  - Inputs: px_valid, ink, bx, row_end.
  - Outputs the 8 threshold bits when row_end is set.

Test Plan:
- All-zero RAM, start -> done at T+1026; bbox_valid=0, bbox fields 0, pixel_count=0, feature=0.
- All-ones RAM -> bbox (0,0)-(31,31), pixel_count=1024, feature=all ones.
- Single ink pixel at (5,9), THRESH=1 -> bbox min=max=(5,9), pixel_count=1, feature bit 17 only. Same image with THRESH=4 -> feature=0, bbox unchanged.
- Full 4x4 block at x 8..11, y 28..31 plus 3 pixels in block (0,0), THRESH=4 -> feature bit 58 only; bbox (0,0)-(11,31) if the 3 pixels include (0,0); pixel_count=19.
- start pulsed again at T+100 -> ignored; exactly one done at T+1026 and rd_addr sequence unbroken.
- rst at T+500 -> busy=0 next cycle, no done, outputs at reset values. A new start then produces correct results.

Source files
------------

// File: rtl/canvas_pkg.sv
// Shared canvas geometry, feature-map sizing and scanner state encoding,
// used by both the stroke writer and the canvas scanner.
package canvas_pkg;
  localparam int CANVAS_DIM    = 32;
  localparam int CANVAS_ADDR_W = 10;
  localparam int CELL_SHIFT    = 5;
  localparam int BLK_DIM       = 4;
  localparam int FEAT_DIM      = 8;
  localparam int FEAT_W        = 64;

  localparam logic [CELL_SHIFT-1:0]    MAX_COORD = '1;
  localparam logic [CANVAS_ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} scan_state_e;
endpackage

// File: rtl/canvas_scanner_block_row_accum.sv
// Eight per-block ink counters for the current 4-row band; emits the
// thresholded feature bits for the whole band on its last pixel.
module block_row_accum
  import canvas_pkg::*;
#(
  parameter int THRESH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                px_valid_i,
  input  logic                ink_i,
  input  logic [2:0]          bx_i,
  input  logic                row_end_i,
  output logic [FEAT_DIM-1:0] feat_row_o
);

  logic [4:0] cnt_q   [FEAT_DIM];
  logic [4:0] cnt_eff [FEAT_DIM];

  // The band's final pixel is folded in before thresholding.
  always_comb begin
    for (int b = 0; b < FEAT_DIM; b++) begin
      cnt_eff[b]    = cnt_q[b] + ((px_valid_i && ink_i && (bx_i == 3'(b))) ? 5'd1 : 5'd0);
      feat_row_o[b] = (cnt_eff[b] >= 5'(THRESH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i || row_end_i) begin
      for (int b = 0; b < FEAT_DIM; b++) cnt_q[b] <= '0;
    end else if (px_valid_i && ink_i) begin
      cnt_q[bx_i] <= cnt_q[bx_i] + 5'd1;
    end
  end

endmodule

// File: rtl/canvas_scanner.sv
// Raster-scans the 32x32 canvas RAM read port and produces ink bounding box,
// ink count and an 8x8 thresholded feature bitmap for the recogniser.
module canvas_scanner
  import canvas_pkg::*;
#(
  parameter int THRESH = 4,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     rd_en,
  output logic [CANVAS_ADDR_W-1:0] rd_addr,
  input  logic                     rd_data,
  output logic                     busy,
  output logic                     done,
  output logic                     bbox_valid,
  output logic [CELL_SHIFT-1:0]    min_x,
  output logic [CELL_SHIFT-1:0]    min_y,
  output logic [CELL_SHIFT-1:0]    max_x,
  output logic [CELL_SHIFT-1:0]    max_y,
  output logic [10:0]              pixel_count,
  output logic [FEAT_W-1:0]        feature
);

  if (RD_LAT != 1) begin : g_rd_lat_check
    $error("canvas_scanner: only RD_LAT=1 is supported");
  end
  if (THRESH < 1 || THRESH > BLK_DIM * BLK_DIM) begin : g_thresh_check
    $error("canvas_scanner: THRESH must be 1..16");
  end

  scan_state_e               state_q;
  logic                      rd_en_q, busy_q, done_q;
  logic [CANVAS_ADDR_W-1:0]  rd_addr_q;
  logic                      px_valid_q;
  logic [CELL_SHIFT-1:0]     px_x_q, px_y_q;
  logic                      bbox_valid_q, bbox_valid_d;
  logic [CELL_SHIFT-1:0]     min_x_q, min_y_q, max_x_q, max_y_q;
  logic [CELL_SHIFT-1:0]     min_x_d, min_y_d, max_x_d, max_y_d;
  logic [10:0]               pixel_count_q, pixel_count_d;
  logic [FEAT_W-1:0]         feature_q, feature_d;
  logic                      hit, row_end, clr;
  logic [FEAT_DIM-1:0]       feat_row;

  assign clr = (state_q == IDLE) && start;

  block_row_accum #(.THRESH(THRESH)) u_accum (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr),
    .px_valid_i (px_valid_q),
    .ink_i      (rd_data),
    .bx_i       (px_x_q[4:2]),
    .row_end_i  (row_end),
    .feat_row_o (feat_row)
  );

  // Stage p1: rd_data is paired with the coordinates registered last cycle.
  always_comb begin
    hit           = px_valid_q & rd_data;
    row_end       = px_valid_q && (px_x_q == MAX_COORD) && (px_y_q[1:0] == 2'd3);
    bbox_valid_d  = bbox_valid_q | hit;
    pixel_count_d = pixel_count_q + {10'd0, hit};
    min_x_d       = (hit && (px_x_q < min_x_q)) ? px_x_q : min_x_q;
    min_y_d       = (hit && (px_y_q < min_y_q)) ? px_y_q : min_y_q;
    max_x_d       = (hit && (px_x_q > max_x_q)) ? px_x_q : max_x_q;
    max_y_d       = (hit && (px_y_q > max_y_q)) ? px_y_q : max_y_q;
    feature_d     = feature_q;
    if (row_end) feature_d[{px_y_q[4:2], 3'b000} +: FEAT_DIM] = feat_row;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      px_valid_q    <= 1'b0;
      px_x_q        <= '0;
      px_y_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      bbox_valid_q  <= 1'b0;
      min_x_q       <= '0;
      min_y_q       <= '0;
      max_x_q       <= '0;
      max_y_q       <= '0;
      pixel_count_q <= '0;
      feature_q     <= '0;
    end else begin
      done_q     <= 1'b0;
      px_valid_q <= rd_en_q;
      px_x_q     <= rd_addr_q[4:0];
      px_y_q     <= rd_addr_q[9:5];
      case (state_q)
        IDLE: if (start) begin
          state_q       <= SCAN;
          busy_q        <= 1'b1;
          rd_en_q       <= 1'b1;
          rd_addr_q     <= '0;
          bbox_valid_q  <= 1'b0;
          min_x_q       <= MAX_COORD;
          min_y_q       <= MAX_COORD;
          max_x_q       <= '0;
          max_y_q       <= '0;
          pixel_count_q <= '0;
          feature_q     <= '0;
        end
        SCAN: begin
          bbox_valid_q  <= bbox_valid_d;
          pixel_count_q <= pixel_count_d;
          feature_q     <= feature_d;
          min_x_q       <= min_x_d;
          min_y_q       <= min_y_d;
          max_x_q       <= max_x_d;
          max_y_q       <= max_y_d;
          if (rd_addr_q == LAST_ADDR) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            rd_addr_q <= rd_addr_q + 10'd1;
          end
        end
        DRAIN: begin
          state_q       <= DONE;
          done_q        <= 1'b1;
          bbox_valid_q  <= bbox_valid_d;
          pixel_count_q <= pixel_count_d;
          feature_q     <= feature_d;
          // An empty canvas must not expose the 31/0 seed values.
          if (bbox_valid_d) begin
            min_x_q <= min_x_d;
            min_y_q <= min_y_d;
            max_x_q <= max_x_d;
            max_y_q <= max_y_d;
          end else begin
            min_x_q <= '0;
            min_y_q <= '0;
            max_x_q <= '0;
            max_y_q <= '0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign bbox_valid  = bbox_valid_q;
  assign min_x       = min_x_q;
  assign min_y       = min_y_q;
  assign max_x       = max_x_q;
  assign max_y       = max_y_q;
  assign pixel_count = pixel_count_q;
  assign feature     = feature_q;

endmodule

// File: tb/tb_canvas_scanner.sv
// Bench for canvas_scanner: two instances (THRESH=4 and THRESH=1) read a shared
// canvas image; an image-level model predicts timing and results.
module tb_canvas_scanner;

  typedef struct packed {
    logic        bv;
    logic [4:0]  mnx, mny, mxx, mxy;
    logic [10:0] cnt;
    logic [63:0] feat;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0;
  logic        rd_en4, rd_en1;
  logic [9:0]  rd_addr4, rd_addr1;
  logic        rd_data4 = 1'b0, rd_data1 = 1'b0;
  logic        busy4, busy1, done4, done1, bv4, bv1;
  logic [4:0]  mnx4, mny4, mxx4, mxy4, mnx1, mny1, mxx1, mxy1;
  logic [10:0] cnt4, cnt1;
  logic [63:0] feat4, feat1;

  logic mem [1024];
  int   checks = 0, errors = 0;
  int   k = 0;
  bit   armed = 1'b0;
  int   done_cnt = 0;
  res_t exp4 = '0, exp1 = '0;

  canvas_scanner #(.THRESH(4), .RD_LAT(1)) dut4 (
    .clk(clk), .rst(rst), .start(start), .rd_en(rd_en4), .rd_addr(rd_addr4),
    .rd_data(rd_data4), .busy(busy4), .done(done4), .bbox_valid(bv4),
    .min_x(mnx4), .min_y(mny4), .max_x(mxx4), .max_y(mxy4),
    .pixel_count(cnt4), .feature(feat4)
  );

  canvas_scanner #(.THRESH(1), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .rd_en(rd_en1), .rd_addr(rd_addr1),
    .rd_data(rd_data1), .busy(busy1), .done(done1), .bbox_valid(bv1),
    .min_x(mnx1), .min_y(mny1), .max_x(mxx1), .max_y(mxy1),
    .pixel_count(cnt1), .feature(feat1)
  );

  // Canvas RAM read ports, one cycle latency.
  always @(posedge clk) begin
    if (rd_en4) rd_data4 <= mem[rd_addr4];
    if (rd_en1) rd_data1 <= mem[rd_addr1];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic res_t model(input int thresh);
    res_t r;
    int blk[64];
    int mnx, mny, mxx, mxy;
    r = '0;
    mnx = 31; mny = 31; mxx = 0; mxy = 0;
    for (int b = 0; b < 64; b++) blk[b] = 0;
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++)
        if (mem[y*32 + x] == 1'b1) begin
          r.cnt = r.cnt + 11'd1;
          r.bv  = 1'b1;
          if (x < mnx) mnx = x;
          if (y < mny) mny = y;
          if (x > mxx) mxx = x;
          if (y > mxy) mxy = y;
          blk[(y/4)*8 + x/4]++;
        end
    if (r.bv) begin
      r.mnx = 5'(mnx); r.mny = 5'(mny); r.mxx = 5'(mxx); r.mxy = 5'(mxy);
    end
    for (int b = 0; b < 64; b++) r.feat[b] = (blk[b] >= thresh);
    return r;
  endfunction

  // k counts cycles since an accepted start: busy for k=1..1026, done at 1026.
  always @(posedge clk) begin
    if (rst) begin
      armed = 1'b1;
      k     = 0;
      exp4  = '0;
      exp1  = '0;
    end else if (k == 0) begin
      if (start) k = 1;
    end else if (k == 1026) begin
      k = 0;
    end else begin
      k++;
      if (k == 1026) begin
        exp4 = model(4);
        exp1 = model(1);
      end
    end
  end

  task automatic cmp_res(input string tag, input res_t e, input logic bv,
                         input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                         input logic [4:0] d, input logic [10:0] n, input logic [63:0] f);
    chk({tag, "_bbox_valid"}, 64'(bv), 64'(e.bv));
    chk({tag, "_min_x"}, 64'(a), 64'(e.mnx));
    chk({tag, "_min_y"}, 64'(b), 64'(e.mny));
    chk({tag, "_max_x"}, 64'(c), 64'(e.mxx));
    chk({tag, "_max_y"}, 64'(d), 64'(e.mxy));
    chk({tag, "_pixel_count"}, 64'(n), 64'(e.cnt));
    chk({tag, "_feature"}, f, e.feat);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("busy4", 64'(busy4), 64'(k != 0));
      chk("busy1", 64'(busy1), 64'(k != 0));
      chk("rd_en4", 64'(rd_en4), 64'(k >= 1 && k <= 1024));
      chk("rd_en1", 64'(rd_en1), 64'(k >= 1 && k <= 1024));
      chk("done4", 64'(done4), 64'(k == 1026));
      chk("done1", 64'(done1), 64'(k == 1026));
      if (k >= 1 && k <= 1024) begin
        chk("rd_addr4", 64'(rd_addr4), 64'(k - 1));
        chk("rd_addr1", 64'(rd_addr1), 64'(k - 1));
      end
      if (done4) done_cnt++;
      if (k == 0 || k == 1026) begin
        cmp_res("t4", exp4, bv4, mnx4, mny4, mxx4, mxy4, cnt4, feat4);
        cmp_res("t1", exp1, bv1, mnx1, mny1, mxx1, mxy1, cnt1, feat1);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic scan(input int restart_at);
    int b;
    int d0;
    d0 = done_cnt;
    start = 1'b1; cyc(1); start = 1'b0;
    if (restart_at > 0) begin
      cyc(restart_at - 1);
      start = 1'b1; cyc(1); start = 1'b0;
    end
    b = 0;
    while (busy4 && b < 1200) begin
      cyc(1);
      b++;
    end
    chk("scan_busy_end", 64'(busy4), 64'd0);
    chk("done_once", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 1'b0;
  endtask

  initial begin
    int d0;
    clear_mem();
    rst = 1'b1; cyc(3); rst = 1'b0; cyc(1);
    chk("rst_busy", 64'(busy4), 64'd0);
    chk("rst_rd_en", 64'(rd_en4), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr4), 64'd0);
    chk("rst_pixel_count", 64'(cnt4), 64'd0);
    chk("rst_feature", feat4, 64'd0);

    // Empty canvas
    scan(0);
    chk("empty_bv", 64'(bv4), 64'd0);
    chk("empty_bbox", 64'({mnx4, mny4, mxx4, mxy4}), 64'd0);
    chk("empty_cnt", 64'(cnt4), 64'd0);
    chk("empty_feat1", feat1, 64'd0);

    // Full canvas
    for (int i = 0; i < 1024; i++) mem[i] = 1'b1;
    scan(0);
    chk("full_bbox", 64'({mnx4, mny4, mxx4, mxy4}), 64'({5'd0, 5'd0, 5'd31, 5'd31}));
    chk("full_cnt", 64'(cnt4), 64'd1024);
    chk("full_feat4", feat4, {64{1'b1}});

    // Single pixel at (5,9)
    clear_mem();
    mem[9*32 + 5] = 1'b1;
    scan(0);
    chk("single_bbox", 64'({mnx4, mny4, mxx4, mxy4}), 64'({5'd5, 5'd9, 5'd5, 5'd9}));
    chk("single_cnt", 64'(cnt4), 64'd1);
    chk("single_feat1", feat1, 64'h0000_0000_0002_0000);
    chk("single_feat4", feat4, 64'd0);

    // Full block (2,7) plus three pixels in block (0,0); restart attempt ignored
    clear_mem();
    for (int y = 28; y < 32; y++)
      for (int x = 8; x < 12; x++) mem[y*32 + x] = 1'b1;
    mem[0] = 1'b1; mem[1] = 1'b1; mem[32] = 1'b1;
    scan(100);
    chk("block_bbox", 64'({mnx4, mny4, mxx4, mxy4}), 64'({5'd0, 5'd0, 5'd11, 5'd31}));
    chk("block_cnt", 64'(cnt4), 64'd19);
    chk("block_feat4", feat4, 64'h0400_0000_0000_0000);
    chk("block_feat1", feat1, 64'h0400_0000_0000_0001);

    // Reset in the middle of a scan
    d0 = done_cnt;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(498);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("midrst_busy", 64'(busy4), 64'd0);
    chk("midrst_cnt", 64'(cnt4), 64'd0);
    chk("midrst_feat", feat4, 64'd0);
    cyc(5);
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    scan(0);
    chk("after_rst_cnt", 64'(cnt4), 64'd19);
    chk("after_rst_feat4", feat4, 64'h0400_0000_0000_0000);

    // start coincident with rst is dropped
    rst = 1'b1; start = 1'b1; cyc(1); rst = 1'b0; start = 1'b0;
    cyc(2);
    chk("rst_start_busy", 64'(busy4), 64'd0);
    chk("rst_start_rd_en", 64'(rd_en4), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
